// File: rtl/dram_port_arbiter_pkg.sv
// Shared DDR3 native-port command codes, arbiter state encoding and sizing helper
// for dram_port_arbiter and its write-lead counter.
package dram_port_arbiter_pkg;

  localparam logic [2:0] DDR3CMD_Write = 3'b000;
  localparam logic [2:0] DDR3CMD_Read  = 3'b001;

  typedef enum logic [1:0] {
    ST_Init  = 2'd0,
    ST_Drain = 2'd1,
    ST_Run   = 2'd2
  } arb_state_e;

  function automatic int unsigned lead_width(input int unsigned max_lead);
    return (max_lead < 1) ? 1 : $clog2(max_lead + 1);
  endfunction

endpackage

// File: rtl/dram_port_arbiter_lead_counter.sv
// WriteLeadCounter: up/down count of accepted write commands still waiting for
// their data beat. Callers gate inc/dec so the count never wraps.
module WriteLeadCounter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxWriteLead = 8,
  localparam int unsigned LeadW = lead_width(MaxWriteLead)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             dec,
  output logic [LeadW-1:0] count_next,
  output logic             full,
  output logic             empty
);

  logic [LeadW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      count_d = count_q + LeadW'(1);
    end else if (dec && !inc) begin
      count_d = count_q - LeadW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;
  assign full       = (count_q == LeadW'(MaxWriteLead));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/dram_port_arbiter.sv
// Hands the DDR3 native port from the bucket initializer to the ORAM backend.
// Define DRAM_INIT_SKIP_EN to start directly in the backend-owned state.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned DDRAWidth    = 28,
  parameter int unsigned DDRCWidth    = 3,
  parameter int unsigned DDRDWidth    = 512,
  parameter int unsigned DDRMWidth    = 64,
  parameter int unsigned MaxWriteLead = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] InitCmdAddr,
  input  logic [DDRCWidth-1:0] InitCmd,
  input  logic                 InitCmdValid,
  output logic                 InitCmdReady,
  input  logic [DDRDWidth-1:0] InitWrData,
  input  logic [DDRMWidth-1:0] InitWrMask,
  input  logic                 InitWrValid,
  output logic                 InitWrReady,
  input  logic                 InitDone,
  input  logic [DDRAWidth-1:0] MainCmdAddr,
  input  logic [DDRCWidth-1:0] MainCmd,
  input  logic                 MainCmdValid,
  output logic                 MainCmdReady,
  input  logic [DDRDWidth-1:0] MainWrData,
  input  logic [DDRMWidth-1:0] MainWrMask,
  input  logic                 MainWrValid,
  output logic                 MainWrReady,
  output logic [DDRAWidth-1:0] DRAMCommandAddress,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMWriteData,
  output logic [DDRMWidth-1:0] DRAMWriteMask,
  output logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  output logic                 Ready
);

  localparam int unsigned LeadW = lead_width(MaxWriteLead);
  localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(DDR3CMD_Write);

`ifdef DRAM_INIT_SKIP_EN
  localparam arb_state_e RstState = ST_Run;
  localparam logic       RstReady = 1'b1;
  logic unused_init_done;
  assign unused_init_done = InitDone;
`else
  localparam arb_state_e RstState = ST_Init;
  localparam logic       RstReady = 1'b0;
`endif

  arb_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic [LeadW-1:0] lead_next;
  logic             lead_full, lead_empty;
  logic             init_cmd_sel, main_cmd_sel, init_dat_sel, main_dat_sel;
  logic             sel_cmd_valid, sel_wr_valid, cmd_is_write;
  logic             cmd_open, dat_open, lead_inc, lead_dec;
  logic [DDRCWidth-1:0] sel_cmd;

  always_comb begin
`ifdef DRAM_INIT_SKIP_EN
    init_cmd_sel = 1'b0;
    init_dat_sel = 1'b0;
`else
    init_cmd_sel = (state_q == ST_Init);
    init_dat_sel = (state_q == ST_Init) || (state_q == ST_Drain);
`endif
    main_cmd_sel  = (state_q == ST_Run);
    main_dat_sel  = (state_q == ST_Run);
    sel_cmd       = main_cmd_sel ? MainCmd : InitCmd;
    sel_cmd_valid = (init_cmd_sel & InitCmdValid) | (main_cmd_sel & MainCmdValid);
    sel_wr_valid  = (init_dat_sel & InitWrValid) | (main_dat_sel & MainWrValid);
    cmd_is_write  = (sel_cmd == CmdWrite);
    // Reads bypass the lead limit; a full lead only holds back writes.
    cmd_open      = ~Reset & ~(cmd_is_write & lead_full);
    dat_open      = ~Reset & ~lead_empty;
  end

  assign DRAMCommandAddress = main_cmd_sel ? MainCmdAddr : InitCmdAddr;
  assign DRAMCommand        = sel_cmd;
  assign DRAMCommandValid   = sel_cmd_valid & cmd_open;
  assign InitCmdReady       = init_cmd_sel & cmd_open & DRAMCommandReady;
  assign MainCmdReady       = main_cmd_sel & cmd_open & DRAMCommandReady;

  assign DRAMWriteData      = main_dat_sel ? MainWrData : InitWrData;
  assign DRAMWriteMask      = main_dat_sel ? MainWrMask : InitWrMask;
  assign DRAMWriteDataValid = sel_wr_valid & dat_open;
  assign InitWrReady        = init_dat_sel & dat_open & DRAMWriteDataReady;
  assign MainWrReady        = main_dat_sel & dat_open & DRAMWriteDataReady;

  assign lead_inc = DRAMCommandValid & DRAMCommandReady & cmd_is_write;
  assign lead_dec = DRAMWriteDataValid & DRAMWriteDataReady;

  WriteLeadCounter #(
    .MaxWriteLead(MaxWriteLead)
  ) u_lead (
    .Clock     (Clock),
    .Reset     (Reset),
    .inc       (lead_inc),
    .dec       (lead_dec),
    .count_next(lead_next),
    .full      (lead_full),
    .empty     (lead_empty)
  );

  // Hand-off looks at the post-update lead so a write accepted in the same
  // cycle as InitDone keeps the port in the initializer's hands until drained.
  always_comb begin
    state_d = state_q;
`ifdef DRAM_INIT_SKIP_EN
    state_d = ST_Run;
`else
    unique case (state_q)
      ST_Init:  if (InitDone) state_d = (lead_next == '0) ? ST_Run : ST_Drain;
      ST_Drain: if (lead_next == '0) state_d = ST_Run;
      ST_Run:   state_d = ST_Run;
      default:  state_d = ST_Init;
    endcase
`endif
    ready_d = (state_d == ST_Run);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RstState;
      ready_q <= RstReady;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  assign Ready = ready_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: random requester traffic against an
// ordered-stream reference model, plus directed reset-in-drain checks.
`timescale 1ns/1ps
module tb_dram_port_arbiter;
  import dram_port_arbiter_pkg::*;

  localparam int AW = 28, CW = 3, DW = 64, MW = 8, MAXL = 2;
  localparam int N_INIT = 6, N_MAIN = 24, TIMEOUT = 3000;
  localparam logic [CW-1:0] WR = DDR3CMD_Write;
  localparam logic [CW-1:0] RD = DDR3CMD_Read;

  logic Clock = 1'b0;
  logic Reset;
  logic [AW-1:0] InitCmdAddr, MainCmdAddr, DRAMCommandAddress;
  logic [CW-1:0] InitCmd, MainCmd, DRAMCommand;
  logic [DW-1:0] InitWrData, MainWrData, DRAMWriteData;
  logic [MW-1:0] InitWrMask, MainWrMask, DRAMWriteMask;
  logic InitCmdValid, InitCmdReady, InitWrValid, InitWrReady, InitDone;
  logic MainCmdValid, MainCmdReady, MainWrValid, MainWrReady;
  logic DRAMCommandValid, DRAMCommandReady, DRAMWriteDataValid, DRAMWriteDataReady;
  logic Ready;

  always #5 Clock = ~Clock;

  dram_port_arbiter #(
    .DDRAWidth(AW), .DDRCWidth(CW), .DDRDWidth(DW), .DDRMWidth(MW), .MaxWriteLead(MAXL)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .InitCmdAddr(InitCmdAddr), .InitCmd(InitCmd), .InitCmdValid(InitCmdValid),
    .InitCmdReady(InitCmdReady), .InitWrData(InitWrData), .InitWrMask(InitWrMask),
    .InitWrValid(InitWrValid), .InitWrReady(InitWrReady), .InitDone(InitDone),
    .MainCmdAddr(MainCmdAddr), .MainCmd(MainCmd), .MainCmdValid(MainCmdValid),
    .MainCmdReady(MainCmdReady), .MainWrData(MainWrData), .MainWrMask(MainWrMask),
    .MainWrValid(MainWrValid), .MainWrReady(MainWrReady),
    .DRAMCommandAddress(DRAMCommandAddress), .DRAMCommand(DRAMCommand),
    .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
    .DRAMWriteData(DRAMWriteData), .DRAMWriteMask(DRAMWriteMask),
    .DRAMWriteDataValid(DRAMWriteDataValid), .DRAMWriteDataReady(DRAMWriteDataReady),
    .Ready(Ready)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [CW-1:0] cmd;} cmd_t;
  typedef struct packed {logic [DW-1:0] data; logic [MW-1:0] mask;} dat_t;

  cmd_t exp_cmd[$], init_cmds[$], main_cmds[$];
  dat_t exp_dat[$], init_dats[$], main_dats[$];
  int   compared = 0, mismatched = 0;
  bit   mon_en = 1'b0, stim_done = 1'b0, exp_ready = 1'b0;
  int   model_lead = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic ch_rdy(input int ch);
    case (ch)
      0: return InitCmdReady;
      1: return InitWrReady;
      2: return MainCmdReady;
      default: return MainWrReady;
    endcase
  endfunction

  task automatic wait_accept(input int ch);
    int n = 0;
    @(negedge Clock);
    while (!ch_rdy(ch) && n < TIMEOUT) begin
      @(negedge Clock);
      n++;
    end
    compared++;
    if (!ch_rdy(ch)) begin
      mismatched++;
      $display("FAIL handshake_timeout ch=%0d: ready stayed 0 for %0d cycles, expected 1", ch, n);
    end
    @(posedge Clock); #1;
  endtask

  // Monitor: model sees the DRAM port as two ordered streams; lead is commands minus beats.
  initial forever begin
    cmd_t e;
    dat_t ed;
    @(negedge Clock);
    if (mon_en && !Reset) begin
      check("ready", Ready, exp_ready);
      if (!exp_ready) check("main_blocked", MainCmdReady | MainWrReady, 0);
      else            check("init_blocked", InitCmdReady | InitWrReady, 0);
      if (DRAMWriteDataValid) check("data_before_cmd", model_lead > 0, 1);
      if (DRAMCommandValid && DRAMCommand == WR) check("lead_limit", model_lead < MAXL, 1);
      if (DRAMCommandValid && DRAMCommandReady) begin
        if (exp_cmd.size() == 0) check("cmd_extra", 1, 0);
        else begin
          e = exp_cmd.pop_front();
          check("cmd", {DRAMCommandAddress, DRAMCommand}, e);
        end
        if (DRAMCommand == WR) model_lead++;
      end
      if (DRAMWriteDataValid && DRAMWriteDataReady) begin
        if (exp_dat.size() == 0) check("data_extra", 1, 0);
        else begin
          ed = exp_dat.pop_front();
          check("wdata", {DRAMWriteData, DRAMWriteMask}, ed);
        end
        model_lead--;
      end
      if (InitDone && model_lead == 0) exp_ready = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    dat_t d;
    Reset = 1'b1; InitDone = 1'b0;
    InitCmdAddr = '0; InitCmd = WR; InitCmdValid = 1'b1;
    InitWrData = '0; InitWrMask = '0; InitWrValid = 1'b1;
    MainCmdAddr = '0; MainCmd = WR; MainCmdValid = 1'b1;
    MainWrData = '0; MainWrMask = '0; MainWrValid = 1'b1;
    DRAMCommandReady = 1'b1; DRAMWriteDataReady = 1'b1;

`ifndef DRAM_INIT_SKIP_EN
    for (int i = 0; i < N_INIT; i++) begin
      c.addr = AW'(i); c.cmd = WR;
      init_cmds.push_back(c); exp_cmd.push_back(c);
      d.data = {$urandom, $urandom}; d.mask = MW'($urandom);
      init_dats.push_back(d); exp_dat.push_back(d);
    end
`else
    exp_ready = 1'b1;
`endif
    for (int i = 0; i < N_MAIN; i++) begin
      c.addr = AW'($urandom); c.cmd = ($urandom_range(0, 1) == 1) ? WR : RD;
      main_cmds.push_back(c); exp_cmd.push_back(c);
      if (c.cmd == WR) begin
        d.data = {$urandom, $urandom}; d.mask = MW'($urandom);
        main_dats.push_back(d); exp_dat.push_back(d);
      end
    end

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_cmd_valid", DRAMCommandValid, 0);
    check("rst_data_valid", DRAMWriteDataValid, 0);
    check("rst_req_ready", {InitCmdReady, InitWrReady, MainCmdReady, MainWrReady}, 0);
`ifdef DRAM_INIT_SKIP_EN
    check("rst_ready", Ready, 1);
`else
    check("rst_ready", Ready, 0);
`endif

    @(posedge Clock); #1;
    InitCmdValid = 1'b0; InitWrValid = 1'b0; MainCmdValid = 1'b0; MainWrValid = 1'b0;
    Reset = 1'b0; mon_en = 1'b1;

    fork
      begin
        fork
          begin
            foreach (init_cmds[i]) begin
              repeat ($urandom_range(0, 2)) begin @(posedge Clock); #1; end
              InitCmdAddr = init_cmds[i].addr; InitCmd = init_cmds[i].cmd; InitCmdValid = 1'b1;
              wait_accept(0);
              InitCmdValid = 1'b0;
            end
            InitDone = 1'b1;
          end
          begin
            foreach (init_dats[i]) begin
              repeat ($urandom_range(0, 4)) begin @(posedge Clock); #1; end
              InitWrData = init_dats[i].data; InitWrMask = init_dats[i].mask; InitWrValid = 1'b1;
              wait_accept(1);
              InitWrValid = 1'b0;
            end
          end
          begin
            foreach (main_cmds[i]) begin
              repeat ($urandom_range(0, 2)) begin @(posedge Clock); #1; end
              MainCmdAddr = main_cmds[i].addr; MainCmd = main_cmds[i].cmd; MainCmdValid = 1'b1;
              wait_accept(2);
              MainCmdValid = 1'b0;
            end
          end
          begin
            foreach (main_dats[i]) begin
              repeat ($urandom_range(0, 4)) begin @(posedge Clock); #1; end
              MainWrData = main_dats[i].data; MainWrMask = main_dats[i].mask; MainWrValid = 1'b1;
              wait_accept(3);
              MainWrValid = 1'b0;
            end
          end
        join
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge Clock); #1;
          DRAMCommandReady   = ($urandom_range(0, 3) != 0);
          DRAMWriteDataReady = ($urandom_range(0, 3) != 0);
        end
      end
    join

    repeat (2) @(negedge Clock);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("data_queue_drained", exp_dat.size(), 0);
    check("final_lead", model_lead, 0);
    check("final_ready", Ready, 1);

`ifndef DRAM_INIT_SKIP_EN
    // Reset while draining with two writes outstanding.
    mon_en = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1; InitDone = 1'b0;
    DRAMCommandReady = 1'b1; DRAMWriteDataReady = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    InitCmd = WR; InitCmdAddr = AW'(0); InitCmdValid = 1'b1;
    wait_accept(0);
    InitCmdAddr = AW'(1);
    wait_accept(0);
    InitDone = 1'b1;
    InitCmdAddr = AW'(2);
    MainCmd = RD; MainCmdValid = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    check("drain_ready", Ready, 0);
    check("drain_cmd_blocked", {DRAMCommandValid, InitCmdReady, MainCmdReady}, 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    InitWrValid = 1'b1; MainWrValid = 1'b1;
    @(negedge Clock);
    check("reset_valids", {DRAMCommandValid, DRAMWriteDataValid}, 0);
    check("reset_readies", {InitCmdReady, InitWrReady, MainCmdReady, MainWrReady}, 0);
    @(posedge Clock); #1;
    Reset = 1'b0; InitDone = 1'b0;
    @(negedge Clock);
    check("post_reset_ready", Ready, 0);
    check("post_reset_lead0_data", DRAMWriteDataValid, 0);
    check("post_reset_init_cmd", {DRAMCommandValid, InitCmdReady, MainCmdReady}, 3'b110);
    @(posedge Clock); #1;
    InitCmdValid = 1'b0;
    @(negedge Clock);
    check("data_after_cmd", {DRAMWriteDataValid, InitWrReady}, 2'b11);
    @(posedge Clock); #1;
    InitWrValid = 1'b0; MainWrValid = 1'b0; MainCmdValid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
